// File: rtl/pat_scan_pkg.sv
// Shared types and default constants for the pattern scan coprocessor.
package pat_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LDPAT,
    SCAN,
    WR0,
    WR1,
    WR2,
    DONE
  } state_t;

  localparam int         CNT_W      = 8;
  localparam int         NBYTES_D   = 32;
  localparam logic [7:0] MSG_BASE_D = 8'd0;
  localparam logic [7:0] PAT_ADDR_D = 8'd32;
  localparam logic [7:0] RES_ADDR_D = 8'd33;

endpackage

// File: rtl/pat_scan_engine_win_match.sv
// Per-byte window matcher: four windows wholly inside cur, four straddling
// the boundary between the previous byte's low nibble and cur.
module win_match (
  input  logic [4:0] pat5,
  input  logic [3:0] prev,
  input  logic [7:0] cur,
  input  logic       first,
  output logic [2:0] in_cnt,
  output logic [2:0] cross_cnt,
  output logic       any_in
);

  // bits[k+4:k] for k=0..3 lies inside cur; k=4..7 crosses into prev.
  logic [11:0] bits;
  logic [7:0]  hit;

  assign bits = {prev, cur};

  for (genvar k = 0; k < 8; k++) begin : g_win
    assign hit[k] = (bits[k+4:k] == pat5);
  end

  // Popcount the window hits; the first byte has no predecessor to cross into.
  always_comb begin
    in_cnt    = 3'(hit[0]) + 3'(hit[1]) + 3'(hit[2]) + 3'(hit[3]);
    cross_cnt = 3'(hit[4]) + 3'(hit[5]) + 3'(hit[6]) + 3'(hit[7]);
    if (first) cross_cnt = 3'd0;
    any_in    = |hit[3:0];
  end

endmodule

// File: rtl/pat_scan_engine.sv
// Pattern scan coprocessor: loads a 5-bit pattern, scans a message one byte
// per cycle over the shared data-memory port, then writes three counts back.
module pat_scan_engine
  import pat_scan_pkg::*;
#(
  parameter logic [7:0] MSG_BASE = MSG_BASE_D,
  parameter int         NBYTES   = NBYTES_D,
  parameter logic [7:0] PAT_ADDR = PAT_ADDR_D,
  parameter logic [7:0] RES_ADDR = RES_ADDR_D
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic       mem_we,
  output logic [7:0] mem_wdata
);

  state_t           state, state_nx;
  logic [4:0]       pat5;
  logic [3:0]       prev;
  logic [7:0]       idx;
  logic [CNT_W-1:0] ctb, cto, cts;
  logic [2:0]       in_cnt, cross_cnt;
  logic             any_in;
  logic             last_byte;

  assign last_byte = (idx == 8'(NBYTES - 1));

  win_match u_win (
    .pat5      (pat5),
    .prev      (prev),
    .cur       (mem_rdata),
    .first     (idx == 8'd0),
    .in_cnt    (in_cnt),
    .cross_cnt (cross_cnt),
    .any_in    (any_in)
  );

  // State register, pattern latch, scan index and count accumulators.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
      pat5  <= '0;
      prev  <= '0;
      idx   <= '0;
      ctb   <= '0;
      cto   <= '0;
      cts   <= '0;
    end else begin
      state <= state_nx;
      done  <= (state_nx == DONE);
      case (state)
        LDPAT: begin
          pat5 <= mem_rdata[7:3];
          ctb  <= '0;
          cto  <= '0;
          cts  <= '0;
          idx  <= '0;
        end
        SCAN: begin
          ctb  <= ctb + CNT_W'(in_cnt);
          cto  <= cto + CNT_W'(any_in);
          cts  <= cts + CNT_W'(in_cnt) + CNT_W'(cross_cnt);
          prev <= mem_rdata[3:0];
          idx  <= idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and memory-port mux; the port idles at address 0, no write.
  always_comb begin
    state_nx  = state;
    mem_addr  = 8'd0;
    mem_we    = 1'b0;
    mem_wdata = 8'd0;
    case (state)
      IDLE:  if (start) state_nx = LDPAT;
      LDPAT: begin
        mem_addr = PAT_ADDR;
        state_nx = SCAN;
      end
      SCAN: begin
        mem_addr = MSG_BASE + idx;
        if (last_byte) state_nx = WR0;
      end
      WR0: begin
        mem_we    = 1'b1;
        mem_addr  = RES_ADDR;
        mem_wdata = ctb;
        state_nx  = WR1;
      end
      WR1: begin
        mem_we    = 1'b1;
        mem_addr  = RES_ADDR + 8'd1;
        mem_wdata = cto;
        state_nx  = WR2;
      end
      WR2: begin
        mem_we    = 1'b1;
        mem_addr  = RES_ADDR + 8'd2;
        mem_wdata = cts;
        state_nx  = DONE;
      end
      DONE:  if (start) state_nx = LDPAT;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE) && (state != DONE);

endmodule

// File: doc/pat_scan_engine.md
Name: pat_scan_engine

Overview:
- Memory-side coprocessor for the program-3 search.
- On start, reads the 5-bit pattern and the 32-byte message from data memory.
- Computes three counts: in-byte matches, bytes containing a match, and matches across the 256-bit string including byte crossings.
- Writes the counts back to data memory and raises done. It sits beside data_mem and shares its single read/write port with the core while busy.

Parameters:
- MSG_BASE, 0, address of message byte 0 (MSB-first string).
- NBYTES, 32, message length in bytes.
- PAT_ADDR, 32, pattern byte address; pattern is bits [7:3].
- RES_ADDR, 33, first result address; results go to RES_ADDR, RES_ADDR+1 and RES_ADDR+2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE and DONE; core must not drive memory while high.
- done  out  1  registered; high while in DONE.
- mem_addr  out  8  data-memory address.
- mem_rdata  in  8  data-memory read data; combinational read of mem_addr, same cycle.
- mem_we  out  1  write enable; memory writes on the rising clk edge.
- mem_wdata  out  8  write data.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - All counters and the pattern/previous-byte registers are cleared.
  - Reset mid-operation aborts immediately. No further writes occur; results already written stay in memory.
- FSM IDLE -> LDPAT -> SCAN -> WR0 -> WR1 -> WR2 -> DONE:
  - IDLE: start=1 -> LDPAT.
  - LDPAT: mem_addr=PAT_ADDR; latch pat5=mem_rdata[7:3]; clear ctb, cto, cts; idx=0 -> SCAN.
  - SCAN: mem_addr=MSG_BASE+idx, cur=mem_rdata, one byte per cycle.
    - ctb += number of k in 0..3 with cur[k+4:k]==pat5.
    - cto += 1 if that number is nonzero.
    - cts += the in-byte number, plus for idx>0 the crossing windows {prev[3:0],cur[7]}, {prev[2:0],cur[7:6]}, {prev[1:0],cur[7:5]}, {prev[0],cur[7:4]} equal to pat5.
    - prev<=cur; idx++. Leave SCAN after idx==NBYTES-1 -> WR0.
  - WR0/WR1/WR2: mem_we=1, mem_addr=RES_ADDR+0/1/2, mem_wdata=ctb/cto/cts respectively.
  - DONE: done=1, busy=0. start=1 -> LDPAT with done cleared on the same edge; otherwise hold.
- start outside IDLE/DONE is ignored.
- Latency: done rises on the 36th rising edge after the edge that sampled start (1 LDPAT + 32 SCAN + 3 WR).
- Widths: all counts are 8-bit unsigned and never overflow (max ctb=128, cto=32, cts=252).
  - Per-byte increments are 3-bit; the cts increment per byte is at most 8.
  - The first byte (idx=0) has no crossing windows: 252 windows in total.
- mem_we is high only in WR0-WR2. No writes ever go to message or pattern addresses.

Decomposition:
- Package pat_scan_pkg:
  - state_t enum {IDLE, LDPAT, SCAN, WR0, WR1, WR2, DONE}.
  - Default address constants.
  - Count width localparam CNT_W=8.
- Sub-module win_match (combinational):
  - Inputs: pat5, prev[3:0], cur[7:0], first.
  - Outputs: in_cnt[2:0], cross_cnt[2:0], any_in.
- Top contains only the FSM, address counter, accumulators and memory muxing.

Test Plan:
- pattern byte 0x00, all 32 message bytes 0x00 -> mem[33]=128, mem[34]=32, mem[35]=252; done on the 36th edge after start.
- pattern 0xA8 (10101), all bytes 0x55 -> mem[33]=64, mem[34]=32, mem[35]=126.
- pattern 0xF8 (11111), byte0=0x0F, byte1=0xF0, rest 0x00 -> 0, 0, 4 (pure byte-crossing matches). Then byte5=0xFF only -> 4, 1, 4.
- Reset asserted mid-SCAN (idx=10) -> outputs zero asynchronously, no writes to 33-35, FSM in IDLE. A following start gives correct results.
- start pulsed during SCAN is ignored. start in DONE restarts: done drops next edge, new results are written.
- 200 random pattern/message sets -> results equal a software model of the three counts; mem_we never asserted outside WR states.
